// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port BRAM plus a byte output register.
// Define MEM_ARBITER_RR_EN for round-robin contention; otherwise master 0 has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_we,
  input  logic [31:0] ram_rdata,
  output logic [7:0]  out_byte,
  output logic        out_byte_en,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM = 2'd0,
    TGT_OUT = 2'd1,
    TGT_ERR = 2'd2
  } tgt_t;

  localparam logic [31:0] OUT_ADDR = 32'h1000_0000;

  function automatic tgt_t decode(input logic [31:0] addr);
    if (addr[31:12] == 20'h0) begin
      return TGT_RAM;
    end else if (addr == OUT_ADDR) begin
      return TGT_OUT;
    end else begin
      return TGT_ERR;
    end
  endfunction

  state_t      state_r;
  state_t      state_n_s;
  tgt_t        tgt_r;
  tgt_t        tgt_s;
  logic        gnt_r;
  logic        grant_s;
  logic        req_any_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_wstrb_s;
  logic [9:0]  ram_addr_r;
  logic [31:0] ram_wdata_r;
  logic [3:0]  ram_we_r;
  logic [7:0]  out_byte_r;
  logic        out_byte_en_r;
  logic        err_r;
  logic        m0_ready_r;
  logic        m1_ready_r;
  logic [31:0] resp_data_s;
  logic [31:0] m0_rdata_s;
  logic [31:0] m1_rdata_s;
`ifdef MEM_ARBITER_RR_EN
  logic        last_grant_r;
`endif

  // Pick the winning master and mux its request fields.
  always_comb begin
    grant_s   = 1'b0;
    req_any_s = m0_valid | m1_valid;
    if (m0_valid && m1_valid) begin
`ifdef MEM_ARBITER_RR_EN
      grant_s = ~last_grant_r;
`else
      grant_s = 1'b0;
`endif
    end else if (m1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_wstrb_s = m1_wstrb;
    end else begin
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_wstrb_s = m0_wstrb;
    end
    tgt_s = decode(sel_addr_s);
  end

  // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          state_n_s = ACCESS;
        end else begin
          state_n_s = IDLE;
        end
      end
      ACCESS:  state_n_s = RESP;
      RESP:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State, latched request and all registered outputs; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      tgt_r         <= TGT_RAM;
      gnt_r         <= 1'b0;
      ram_addr_r    <= 10'h0;
      ram_wdata_r   <= 32'h0;
      ram_we_r      <= 4'h0;
      out_byte_r    <= 8'h00;
      out_byte_en_r <= 1'b0;
      err_r         <= 1'b0;
      m0_ready_r    <= 1'b0;
      m1_ready_r    <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      ram_we_r      <= 4'h0;
      out_byte_en_r <= 1'b0;
      err_r         <= 1'b0;
      m0_ready_r    <= 1'b0;
      m1_ready_r    <= 1'b0;
      if (state_r == IDLE && req_any_s) begin
        // Everything the access cycle needs is captured here, so later input changes are ignored.
        gnt_r       <= grant_s;
        tgt_r       <= tgt_s;
        ram_addr_r  <= sel_addr_s[11:2];
        ram_wdata_r <= sel_wdata_s;
        case (tgt_s)
          TGT_RAM: ram_we_r <= sel_wstrb_s;
          TGT_OUT: begin
            if (sel_wstrb_s[0]) begin
              out_byte_r    <= sel_wdata_s[7:0];
              out_byte_en_r <= 1'b1;
            end else begin
              out_byte_en_r <= 1'b0;
            end
          end
          TGT_ERR: err_r <= 1'b1;
          default: err_r <= 1'b1;
        endcase
      end else if (state_r == ACCESS) begin
        m0_ready_r <= ~gnt_r;
        m1_ready_r <= gnt_r;
      end else begin
        gnt_r <= gnt_r;
      end
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Remember the last winner so a tie goes to the other master.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (state_r == IDLE && req_any_s) begin
      last_grant_r <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Response data: BRAM output lands in RESP thanks to its one-cycle latency.
  always_comb begin
    resp_data_s = 32'h0;
    case (tgt_r)
      TGT_RAM: resp_data_s = ram_rdata;
      TGT_OUT: resp_data_s = {24'h0, out_byte_r};
      TGT_ERR: resp_data_s = 32'h0;
      default: resp_data_s = 32'h0;
    endcase
    if (m0_ready_r) begin
      m0_rdata_s = resp_data_s;
    end else begin
      m0_rdata_s = 32'h0;
    end
    if (m1_ready_r) begin
      m1_rdata_s = resp_data_s;
    end else begin
      m1_rdata_s = 32'h0;
    end
  end

  assign m0_ready    = m0_ready_r;
  assign m1_ready    = m1_ready_r;
  assign m0_rdata    = m0_rdata_s;
  assign m1_rdata    = m1_rdata_s;
  assign ram_addr    = ram_addr_r;
  assign ram_wdata   = ram_wdata_r;
  assign ram_we      = ram_we_r;
  assign out_byte    = out_byte_r;
  assign out_byte_en = out_byte_en_r;
  assign err         = err_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural read-first BRAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [7:0]  out_byte;
  logic        out_byte_en, busy, err;

  int check_cnt = 0;
  int err_cnt   = 0;

  logic [31:0] mem [1024] = '{default: 32'h0};

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .out_byte(out_byte), .out_byte_en(out_byte_en), .busy(busy), .err(err)
  );

  // Sync BRAM, read-first, byte enables.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_m0_ready"}, {31'h0, m0_ready}, 32'h0);
    chk({tag, "_m1_ready"}, {31'h0, m1_ready}, 32'h0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    chk({tag, "_ram_we"}, {28'h0, ram_we}, 32'h0);
    chk({tag, "_ram_addr"}, {22'h0, ram_addr}, 32'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    chk({tag, "_out_byte"}, {24'h0, out_byte}, 32'h0);
    chk({tag, "_out_byte_en"}, {31'h0, out_byte_en}, 32'h0);
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // One transaction from IDLE; entered and left at posedge+1.
  task automatic txn(input string name, input int m, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic [31:0] exp_rdata, input logic [3:0] exp_we,
                     input logic exp_oen, input logic exp_err, input logic [7:0] exp_ob);
    logic [31:0] a;
    a = addr;
    if (m == 0) begin
      m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end
    @(posedge clk); #1;
    chk({name, "_acc_busy"}, {31'h0, busy}, 32'h1);
    chk({name, "_acc_we"}, {28'h0, ram_we}, {28'h0, exp_we});
    chk({name, "_acc_oen"}, {31'h0, out_byte_en}, {31'h0, exp_oen});
    chk({name, "_acc_err"}, {31'h0, err}, {31'h0, exp_err});
    chk({name, "_acc_ob"}, {24'h0, out_byte}, {24'h0, exp_ob});
    chk({name, "_acc_rdy"}, {30'h0, m1_ready, m0_ready}, 32'h0);
    if (a[31:12] == 20'h0) chk({name, "_acc_addr"}, {22'h0, ram_addr}, {22'h0, a[11:2]});
    if (exp_we != 4'h0) chk({name, "_acc_wdata"}, ram_wdata, wdata);
    // Drop valid and scramble fields: the in-flight transaction must not notice.
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = 32'hFFFF_FFFC; m1_addr = 32'hFFFF_FFFC;
    m0_wdata = 32'h0BAD_0BAD; m1_wdata = 32'h0BAD_0BAD;
    m0_wstrb = 4'hF; m1_wstrb = 4'hF;
    @(posedge clk); #1;
    chk({name, "_rsp_busy"}, {31'h0, busy}, 32'h1);
    chk({name, "_rsp_we"}, {28'h0, ram_we}, 32'h0);
    chk({name, "_rsp_oen"}, {31'h0, out_byte_en}, 32'h0);
    chk({name, "_rsp_err"}, {31'h0, err}, 32'h0);
    if (m == 0) begin
      chk({name, "_rsp_rdy"}, {30'h0, m1_ready, m0_ready}, 32'h1);
      chk({name, "_rsp_rdata"}, m0_rdata, exp_rdata);
      chk({name, "_rsp_other"}, m1_rdata, 32'h0);
    end else begin
      chk({name, "_rsp_rdy"}, {30'h0, m1_ready, m0_ready}, 32'h2);
      chk({name, "_rsp_rdata"}, m1_rdata, exp_rdata);
      chk({name, "_rsp_other"}, m0_rdata, 32'h0);
    end
    @(posedge clk); #1;
    chk({name, "_end_rdy"}, {30'h0, m1_ready, m0_ready}, 32'h0);
    chk({name, "_end_busy"}, {31'h0, busy}, 32'h0);
    chk({name, "_end_rdata"}, m0_rdata | m1_rdata, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] exp_g;
    rst = 1'b1;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_outs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    //   name        m  addr          wdata         wstrb rdata         we    oen   err   ob
    txn("ram_wr",    0, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00);
    txn("ram_rd",    0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 8'h00);
    txn("out_wr",    1, 32'h1000_0000, 32'h0000_0041, 4'h1, 32'h0000_0041, 4'h0, 1'b1, 1'b0, 8'h41);
    txn("out_rd",    1, 32'h1000_0000, 32'h0,        4'h0, 32'h0000_0041, 4'h0, 1'b0, 1'b0, 8'h41);
    txn("out_nob0",  0, 32'h1000_0000, 32'h0000_0099, 4'h2, 32'h0000_0041, 4'h0, 1'b0, 1'b0, 8'h41);
    txn("err_rd",    0, 32'h2000_0000, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0, 1'b1, 8'h41);
    txn("err_wr",    1, 32'h1000_0004, 32'h1234_5678, 4'hF, 32'h0,        4'h0, 1'b0, 1'b1, 8'h41);
    txn("err_4k",    0, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,        4'h0, 1'b0, 1'b1, 8'h41);
    txn("byte_wr",   1, 32'h0000_0014, 32'h1122_3344, 4'h3, 32'h0,        4'h3, 1'b0, 1'b0, 8'h41);
    txn("byte_rd",   1, 32'h0000_0014, 32'h0,        4'h0, 32'h0000_3344, 4'h0, 1'b0, 1'b0, 8'h41);
    txn("top_wr",    0, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,        4'hF, 1'b0, 1'b0, 8'h41);
    txn("top_rd",    1, 32'h0000_0FFC, 32'h0,        4'h0, 32'hCAFE_F00D, 4'h0, 1'b0, 1'b0, 8'h41);

    // Contention from reset: both masters request reads continuously.
    rst = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h0000_0014; m1_wstrb = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(m0_ready || m1_ready) && n < 6) begin
        @(posedge clk); #1;
        n++;
      end
      chk("arb_wait", {31'h0, (n < 6)}, 32'h1);
`ifdef MEM_ARBITER_RR_EN
      exp_g = (g % 2 == 0) ? 32'h0 : 32'h1;
`else
      exp_g = 32'h0;
`endif
      chk("arb_gnt", {31'h0, m1_ready}, exp_g);
      chk("arb_rdata", m0_rdata | m1_rdata, (exp_g == 32'h0) ? 32'hDEADBEEF : 32'h0000_3344);
      @(posedge clk); #1;
    end
    m0_valid = 1'b0;
    n = 0;
    while (!(m0_ready || m1_ready) && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk("arb_m1_wait", {31'h0, (n < 6)}, 32'h1);
    chk("arb_m1_gnt", {30'h0, m1_ready, m0_ready}, 32'h2);
    m1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arb_idle_busy", {31'h0, busy}, 32'h0);

    // Reset during ACCESS of a RAM write aborts the transaction.
    m0_valid = 1'b1; m0_addr = 32'h0000_0020; m0_wdata = 32'h55AA_55AA; m0_wstrb = 4'hF;
    @(posedge clk); #1;
    chk("abort_acc_we", {28'h0, ram_we}, 32'hF);
    rst = 1'b1;
    m0_valid = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("abort");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_rdy1", {30'h0, m1_ready, m0_ready}, 32'h0);
    chk("abort_busy1", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    chk("abort_rdy2", {30'h0, m1_ready, m0_ready}, 32'h0);
    txn("post_abort", 0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
